// File: rtl/vme_pkg.sv
// vme_pkg: shared definitions for the VME system-controller arbiter.
//   ACTIVE/INACTIVE   levels of the active-low backplane signals
//   ARB_PRI/ARB_RRS   arbitration mode encodings for arb_mode
//   LEVEL_W, level_t  bus-request level width and type
//   arb_state_t       arbiter FSM state encoding
package vme_pkg;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam logic ARB_PRI = 1'b0;
    localparam logic ARB_RRS = 1'b1;

    localparam int LEVEL_W = 2;
    typedef logic [LEVEL_W-1:0] level_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vme_sync.sv
// vme_sync: WIDTH-bit, SYNC_STAGES-deep flop synchroniser for asynchronous
// active-low backplane inputs. On reset every stage holds all-ones, which is
// the INACTIVE level.
//   clock  in   system clock
//   reset  in   synchronous, active-low reset
//   d      in   asynchronous input bus
//   q      out  synchronised copy of d
module vme_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage[i] <= '1;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[SYNC_STAGES-1];

endmodule

// File: rtl/vme_arbiter.sv
// vme_arbiter: VME system-controller bus arbiter. Synchronises BR3..BR0 and
// BBSY, issues one daisy-chain grant at a time, asserts BCLR to a lower
// priority owner when a higher request arrives (PRI mode), and withdraws
// grants that nobody claims within GRANT_TIMEOUT cycles.
//   clock        in   system clock
//   reset        in   synchronous, active-low reset
//   vme_br       in   bus requests, active-low, bit n = level n (3 highest)
//   vme_bbsy     in   bus busy, active-low
//   arb_mode     in   0 = fixed priority, 1 = round robin (sampled in IDLE)
//   vme_bgout    out  bus grant per level, active-low, at most one active
//   vme_bclr     out  bus clear to current owner, active-low
//   arb_owner    out  level of last grant issued
//   arb_busy     out  high in GRANT or BUSY
//   arb_timeout  out  one-cycle pulse when an unclaimed grant is withdrawn
//
// state | meaning
// IDLE  | no grant out; arbitrate when a request is seen and BBSY is released
// GRANT | grant driven, waiting for the new owner to assert BBSY
// BUSY  | owner holds BBSY; BCLR may be raised for higher pending levels
module vme_arbiter
    import vme_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int GRANT_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   vme_br,
    input  logic         vme_bbsy,
    input  logic         arb_mode,
    output logic [3:0]   vme_bgout,
    output logic         vme_bclr,
    output level_t       arb_owner,
    output logic         arb_busy,
    output logic         arb_timeout
);

    localparam int TIMER_W = $clog2(GRANT_TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_TC = TIMER_W'(GRANT_TIMEOUT - 1);

    logic [3:0]         br_s;
    logic               bbsy_s;

    arb_state_t         state, state_d;
    logic [3:0]         bgout_d;
    logic               bclr_d;
    level_t             owner_d;
    logic               timeout_d;
    logic               mode_q, mode_d;
    logic [TIMER_W-1:0] timer, timer_d;
    level_t             sel;

    vme_sync #(
        .WIDTH       (5),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     ({vme_bbsy, vme_br}),
        .q     ({bbsy_s, br_s})
    );

    // Round robin walks last-1, last-2, last-3, last; the final assignment in
    // each loop wins, so candidates are visited from lowest to highest priority.
    function automatic level_t select_level(input logic [3:0] br,
                                            input logic       mode,
                                            input level_t     last);
        level_t lvl;
        level_t cand;
        lvl = '0;
        if (mode == ARB_RRS) begin
            for (int k = 4; k >= 1; k--) begin
                cand = last - level_t'(k);
                if (br[cand] == ACTIVE) lvl = cand;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (br[i] == ACTIVE) lvl = level_t'(i);
            end
        end
        return lvl;
    endfunction

    function automatic logic higher_request(input logic [3:0] br,
                                            input level_t     owner);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(owner) && br[i] == ACTIVE) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        state_d   = state;
        bgout_d   = vme_bgout;
        owner_d   = arb_owner;
        mode_d    = mode_q;
        timer_d   = timer;
        timeout_d = 1'b0;
        bclr_d    = INACTIVE;
        sel       = select_level(br_s, arb_mode, arb_owner);

        case (state)
            IDLE: begin
                if (br_s != 4'b1111 && bbsy_s == INACTIVE) begin
                    bgout_d = ~(4'b0001 << sel);
                    owner_d = sel;
                    mode_d  = arb_mode;
                    timer_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bbsy_s == ACTIVE) begin
                    bgout_d = 4'b1111;
                    state_d = BUSY;
                end else if (timer == TIMER_TC) begin
                    bgout_d   = 4'b1111;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            BUSY: begin
                if (bbsy_s == INACTIVE) state_d = IDLE;
            end
            default: begin
                bgout_d = 4'b1111;
                state_d = IDLE;
            end
        endcase

        // Decided on the next state so BCLR drops on the same edge BUSY is left.
        if (state_d == BUSY && mode_d == ARB_PRI && higher_request(br_s, owner_d))
            bclr_d = ACTIVE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            vme_bgout   <= 4'b1111;
            vme_bclr    <= INACTIVE;
            arb_owner   <= '0;
            arb_busy    <= 1'b0;
            arb_timeout <= 1'b0;
            mode_q      <= ARB_PRI;
            timer       <= '0;
        end else begin
            state       <= state_d;
            vme_bgout   <= bgout_d;
            vme_bclr    <= bclr_d;
            arb_owner   <= owner_d;
            arb_busy    <= (state_d != IDLE);
            arb_timeout <= timeout_d;
            mode_q      <= mode_d;
            timer       <= timer_d;
        end
    end

endmodule
